// File: rtl/riscv_pkg.sv
// Shared fetch-path definitions: instruction width, PC step, reset NOP and FSM states.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_INC = 32'd4;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        StReq,
        StCapt,
        StValid,
        StHalt
    } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch unit. It presents the PC to a one-cycle-latency instruction memory,
// captures the word, and holds it until the consumer takes it. Redirects reload the PC.
// A misaligned redirect target halts fetch until reset.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    output logic [XLEN-1:0]   imem_address,
    input  logic [XLEN-1:0]   imem_data_out,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [XLEN-1:0]   instr,
    output logic [XLEN-1:0]   instr_pc,
    output logic [XLEN-1:0]   instr_pc_plus4,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_target,
    output logic              misaligned_fault,
    output logic [XLEN-1:0]   fetch_count
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] instr_pc_q, instr_pc_d;
    logic [XLEN-1:0] count_q, count_d;
    logic            fault_q, fault_d;

    logic redir_go;
    logic redir_bad;
    logic xfer;

    // HALT ignores both redirects and the consumer handshake.
    assign redir_go  = (state_q != StHalt) && redirect_valid;
    assign redir_bad = redir_go && (redirect_target[1:0] != 2'b00);
    assign xfer      = (state_q == StValid) && instr_ready;

    // FSM state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StReq;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; a redirect overrides the normal REQ -> CAPT -> VALID sequence.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StReq:   state_d = StCapt;
            StCapt:  state_d = StValid;
            StValid: if (instr_ready) state_d = StReq;
            StHalt:  state_d = StHalt;
        endcase
        if (redir_go) begin
            state_d = redir_bad ? StHalt : StReq;
        end
    end

    // FSM outputs.
    always_comb begin
        instr_valid = (state_q == StValid);
    end

    // Datapath next values: PC step or redirect, capture in CAPT, count transfers.
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        count_d    = count_q;
        fault_d    = fault_q | redir_bad;
        if (xfer) begin
            pc_d    = pc_q + PC_INC;
            count_d = count_q + 32'd1;
        end
        if (redir_go) begin
            pc_d = redirect_target;
        end
        // A redirect during CAPT drops the word coming back from memory.
        if ((state_q == StCapt) && !redir_go) begin
            instr_d    = imem_data_out;
            instr_pc_d = pc_q;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            instr_pc_q <= RESET_PC;
            count_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            count_q    <= count_d;
            fault_q    <= fault_d;
        end
    end

    assign imem_address     = pc_q;
    assign instr            = instr_q;
    assign instr_pc         = instr_pc_q;
    assign instr_pc_plus4   = instr_pc_q + PC_INC;
    assign misaligned_fault = fault_q;
    assign fetch_count      = count_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the first fetch address.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: imem_address  out  32  instruction memory address.
REQ-006 Port: imem_data_out  in  32  instruction word, valid one cycle after imem_address is presented.
REQ-007 Port: instr_valid  out  1  instr, instr_pc and instr_pc_plus4 are valid.
REQ-008 Port: instr_ready  in  1  consumer (decoder/core FSM) accepts the instruction.
REQ-009 Port: instr  out  32  fetched instruction word.
REQ-010 Port: instr_pc  out  32  address of instr.
REQ-011 Port: instr_pc_plus4  out  32  instr_pc + 4, mod 2^32.
REQ-012 Port: redirect_valid  in  1  jal, jalr or taken-branch PC update.
REQ-013 Port: redirect_target  in  32  new PC.
REQ-014 Port: misaligned_fault  out  1  sticky fault: redirect target not word-aligned.
REQ-015 Port: fetch_count  out  32  number of accepted instructions.

Function
REQ-016 The FSM SHALL have exactly the states REQ, CAPT, VALID and HALT.
REQ-017 imem_address SHALL equal the internal pc register in every state.
REQ-018 REQ -> CAPT unconditionally, unless a redirect occurs.
REQ-019 CAPT SHALL register imem_data_out into instr and pc into instr_pc, then go to VALID.
REQ-020 In VALID, instr_valid SHALL be 1 and instr, instr_pc and instr_pc_plus4 SHALL hold stable until transfer.
REQ-021 Transfer (instr_valid && instr_ready, no redirect) SHALL set pc <= pc + 4, increment fetch_count, and go to REQ.
REQ-022 Fetch latency: instr_valid rises 2 cycles after the REQ cycle; zero-stall throughput is 1 instruction per 3 cycles.
REQ-023 pc + 4 SHALL wrap: 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-024 An aligned redirect_valid (target[1:0]==0) in REQ, CAPT or VALID SHALL:
- set pc <= redirect_target;
- discard any in-flight or held instruction;
- go to REQ;
- drive instr_valid low on the next cycle.
REQ-025 Redirect and transfer in the same cycle SHALL count as a transfer (fetch_count increments), with pc <= redirect_target.
REQ-026 A redirect with target[1:0]!=0 SHALL set misaligned_fault=1, load pc <= redirect_target, and go to HALT.
REQ-027 HALT SHALL hold instr_valid=0 and misaligned_fault=1, and SHALL ignore redirect_valid and instr_ready until reset.
REQ-028 fetch_count SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-029 instr_ready while instr_valid=0 SHALL have no effect.

Reset
REQ-030 Reset SHALL set:
- state to REQ and pc to RESET_PC;
- instr_valid=0 and instr=32'h0000_0013 (NOP);
- instr_pc=RESET_PC and instr_pc_plus4=RESET_PC+4;
- misaligned_fault=0 and fetch_count=0.
REQ-031 Reset SHALL take priority over redirect, transfer and HALT in the same cycle.
REQ-032 Reset mid-operation SHALL discard the in-flight instruction; the first fetch after reset SHALL be from RESET_PC.

Structure
REQ-033 Package riscv_pkg SHALL hold:
- the fetch state enum;
- constant NOP_INSTR = 32'h0000_0013;
- instruction width 32 and PC increment 4.
REQ-034 The block SHALL be a single module with no sub-module; the PC register, FSM and counter SHALL be inline.

Verification
REQ-035 Reset with RESET_PC=32'h1000 and instr_ready=1 -> instr_pc sequence 0x1000, 0x1004, 0x1008; instr_valid every 3rd cycle; fetch_count=3.
REQ-036 instr_ready=0 for 10 cycles in VALID -> instr and instr_pc stable and fetch_count unchanged; transfer occurs on the first cycle ready=1.
REQ-037 Redirect to 0x2000 during CAPT of 0x1004 -> 0x1004 never presented; next instr_pc=0x2000.
REQ-038 Redirect to 0x3000 coincident with transfer of 0x1008 -> fetch_count increments; next instr_pc=0x3000.
REQ-039 Redirect to 0x2002 -> misaligned_fault=1 next cycle, instr_valid stays 0, later redirects ignored; reset clears the fault and fetch restarts at RESET_PC.
REQ-040 pc=32'hFFFF_FFFC transferred -> instr_pc_plus4=0 and next instr_pc=0.
